// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer on valid/ready.
// Define IMM_GEN_SELECT_CHECK_EN to add the select_error output.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  input  logic [2:0]       in_immediate_select,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_immediate,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_SELECT_CHECK_EN
  ,
  output logic             select_error
`endif
);

  logic [31:0]      imm32;
  logic [XLEN-1:0]  immExt;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q;
  logic [XLEN-1:0]  headImm_q, tailImm_q;
  logic [TAG_W-1:0] headTag_q, tailTag_q;
  logic             push, pop, loadHead, loadTail, shiftTail;

  // Every format's top bit is inst[31] (zimm's is 0), so one 32-bit sign-extend covers XLEN=64.
  always_comb begin
    imm32 = 32'd0;
    case (in_immediate_select)
      3'b001:  imm32 = {{20{in_instruction[31]}}, in_instruction[31:20]};
      3'b010:  imm32 = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
      3'b011:  imm32 = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                        in_instruction[30:25], in_instruction[11:8], 1'b0};
      3'b100:  imm32 = {in_instruction[31:12], 12'd0};
      3'b101:  imm32 = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                        in_instruction[20], in_instruction[30:21], 1'b0};
      3'b110:  imm32 = {27'd0, in_instruction[19:15]};
      default: imm32 = 32'd0;
    endcase
  end

  assign immExt = XLEN'($signed(imm32));

  assign push      = in_valid && in_ready_q;
  assign pop       = (count_q != 2'd0) && out_ready;
  assign loadHead  = push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
  assign loadTail  = push && (count_q == 2'd1) && !pop;
  assign shiftTail = pop && (count_q == 2'd2);

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = 2'd0;
    else if (push && !pop)
      count_d = count_q + 2'd1;
    else if (pop && !push)
      count_d = count_q - 2'd1;
  end

  // in_ready is a registered copy of "room after this edge", so it never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      headImm_q  <= '0;
      headTag_q  <= '0;
      tailImm_q  <= '0;
      tailTag_q  <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
      if (!flush) begin
        if (loadHead) begin
          headImm_q <= immExt;
          headTag_q <= in_tag;
        end else if (shiftTail) begin
          headImm_q <= tailImm_q;
          headTag_q <= tailTag_q;
        end
        if (loadTail) begin
          tailImm_q <= immExt;
          tailTag_q <= in_tag;
        end
      end
    end
  end

`ifdef IMM_GEN_SELECT_CHECK_EN
  logic selErr, headErr_q, tailErr_q;

  assign selErr = (in_immediate_select == 3'b111) ||
                  ((in_immediate_select == 3'b110) && (in_instruction[6:0] != 7'b1110011));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headErr_q <= 1'b0;
      tailErr_q <= 1'b0;
    end else if (!flush) begin
      if (loadHead)
        headErr_q <= selErr;
      else if (shiftTail)
        headErr_q <= tailErr_q;
      if (loadTail)
        tailErr_q <= selErr;
    end
  end

  assign select_error = headErr_q;
`endif

  assign in_ready      = in_ready_q;
  assign out_valid     = (count_q != 2'd0);
  assign out_immediate = headImm_q;
  assign out_tag       = headTag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [2:0]  in_immediate_select;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_immediate;
  logic [3:0]  out_tag;
  logic        in_ready64, out_valid64;
  logic [63:0] out_immediate64;
  logic [3:0]  out_tag64;
`ifdef IMM_GEN_SELECT_CHECK_EN
  logic        select_error, select_error64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_immediate_select(in_immediate_select), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_immediate(out_immediate), .out_tag(out_tag)
`ifdef IMM_GEN_SELECT_CHECK_EN
    , .select_error(select_error)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instruction(in_instruction), .in_immediate_select(in_immediate_select), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_immediate(out_immediate64), .out_tag(out_tag64)
`ifdef IMM_GEN_SELECT_CHECK_EN
    , .select_error(select_error64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [3:0]  tag;
    logic        err;
  } item_t;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [3:0]  tag;
    logic [63:0] exp64;
    logic        expErr;
  } vec_t;

  item_t q[$];
  bit    mReady;
  int    total = 0;
  int    bad   = 0;

  // Reference immediate from the format rules using plain integer field arithmetic.
  function automatic logic [63:0] refImm(input logic [31:0] inst, input logic [2:0] sel);
    longint x, v;
    x = longint'({32'd0, inst});
    v = 0;
    case (sel)
      3'd1: begin v = (x >> 20) & 4095; if (v >= 2048) v -= 4096; end
      3'd2: begin v = (((x >> 25) & 127) << 5) | ((x >> 7) & 31); if (v >= 2048) v -= 4096; end
      3'd3: begin
        v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      3'd4: begin v = x & 64'hFFFFF000; if (v >= 64'h80000000) v -= 64'h100000000; end
      3'd5: begin
        v = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
        if (v >= 1048576) v -= 2097152;
      end
      3'd6: v = (x >> 15) & 31;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic refErr(input logic [31:0] inst, input logic [2:0] sel);
    return (sel == 3'd7) || ((sel == 3'd6) && (inst[6:0] != 7'h73));
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", out_valid, q.size() != 0);
    checkVal("in_ready", in_ready, mReady);
    checkVal("out_valid64", out_valid64, q.size() != 0);
    checkVal("in_ready64", in_ready64, mReady);
    if (q.size() != 0) begin
      checkVal("out_immediate", out_immediate, q[0].imm[31:0]);
      checkVal("out_tag", out_tag, q[0].tag);
      checkVal("out_immediate64", out_immediate64, q[0].imm);
      checkVal("out_tag64", out_tag64, q[0].tag);
`ifdef IMM_GEN_SELECT_CHECK_EN
      checkVal("select_error", select_error, q[0].err);
      checkVal("select_error64", select_error64, q[0].err);
`endif
    end
  endtask

  // Advance one clock with the inputs currently driven, updating the model, then check.
  task automatic applyStimulus();
    bit    push, pop;
    item_t it;
    push = in_valid && mReady && !flush;
    pop  = (q.size() != 0) && out_ready && !flush;
    it.imm = refImm(in_instruction, in_immediate_select);
    it.tag = in_tag;
    it.err = refErr(in_instruction, in_immediate_select);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(it);
    end
    mReady = (q.size() < 2);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] sel, input logic [3:0] tag);
    in_valid = v;
    in_instruction = inst;
    in_immediate_select = sel;
    in_tag = tag;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'hFE112E23, 3'd2, 4'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0});
    vecs.push_back('{32'h12345037, 3'd4, 4'd2, 64'h0000000012345000, 1'b0});
    vecs.push_back('{32'hFFDFF06F, 3'd5, 4'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0});
    vecs.push_back('{32'h000FD073, 3'd6, 4'd4, 64'h000000000000001F, 1'b0});
    vecs.push_back('{32'h000FD013, 3'd6, 4'd5, 64'h000000000000001F, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 3'd0, 4'd6, 64'h0000000000000000, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 3'd7, 4'd7, 64'h0000000000000000, 1'b1});
    vecs.push_back('{32'hFE000EE3, 3'd3, 4'd8, 64'hFFFFFFFFFFFFFFFC, 1'b0});
    vecs.push_back('{32'h80000037, 3'd4, 4'd9, 64'hFFFFFFFF80000000, 1'b0});
    vecs.push_back('{32'h7FF00093, 3'd1, 4'd10, 64'h00000000000007FF, 1'b0});

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    mReady = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd1, 4'd3);

    // Reset held with in_valid high: nothing accepted, outputs cleared.
    repeat (3) begin
      @(negedge clk);
      checkOutput();
      checkVal("reset_out_immediate", out_immediate, 64'd0);
      checkVal("reset_out_tag", out_tag, 64'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    applyStimulus();

    drive(1'b1, 32'hFFF00093, 3'd1, 4'd3);
    applyStimulus();
    checkVal("itype_imm", out_immediate, 64'hFFFFFFFF);
    checkVal("itype_tag", out_tag, 64'd3);

    // Table vectors back-to-back with out_ready high: one result per cycle.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].inst, vecs[i].sel, vecs[i].tag);
      applyStimulus();
      checkVal("tbl_valid", out_valid, 64'd1);
      checkVal("tbl_imm32", out_immediate, vecs[i].exp64[31:0]);
      checkVal("tbl_imm64", out_immediate64, vecs[i].exp64);
      checkVal("tbl_tag", out_tag, vecs[i].tag);
`ifdef IMM_GEN_SELECT_CHECK_EN
      checkVal("tbl_err", select_error, vecs[i].expErr);
`endif
    end
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    applyStimulus();

    // Backpressure: fill both entries, hold, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd1, 4'd1);
    applyStimulus();
    drive(1'b1, 32'hFFF00093, 3'd1, 4'd2);
    applyStimulus();
    checkVal("bp_full_in_ready", in_ready, 64'd0);
    drive(1'b1, 32'h12345037, 3'd4, 4'd11);
    repeat (3) begin
      applyStimulus();
      checkVal("bp_hold_imm", out_immediate, 64'd1);
      checkVal("bp_hold_tag", out_tag, 64'd1);
    end
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    out_ready = 1'b1;
    applyStimulus();
    checkVal("bp_second_tag", out_tag, 64'd2);
    checkVal("bp_ready_back", in_ready, 64'd1);
    applyStimulus();
    checkVal("bp_drained", out_valid, 64'd0);

    // Flush with a simultaneous push: entries and the pushed item all vanish.
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 3'd1, 4'd4);
    applyStimulus();
    drive(1'b1, 32'h00600093, 3'd1, 4'd5);
    applyStimulus();
    flush = 1'b1;
    drive(1'b1, 32'h00700093, 3'd1, 4'd9);
    applyStimulus();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    checkVal("flush_out_valid", out_valid, 64'd0);
    checkVal("flush_in_ready", in_ready, 64'd1);
    out_ready = 1'b1;
    repeat (2) applyStimulus();

    // Refill, then assert reset mid-cycle and look before any clock edge.
    out_ready = 1'b0;
    drive(1'b1, 32'h00800093, 3'd1, 4'd6);
    applyStimulus();
    drive(1'b0, 32'h0, 3'd0, 4'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async_out_valid", out_valid, 64'd0);
    checkVal("async_in_ready", in_ready, 64'd0);
    checkVal("async_out_imm", out_immediate, 64'd0);
    checkVal("async_out_tag", out_tag, 64'd0);
    q.delete();
    mReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] inst;
      logic [2:0]  sel;
      inst = $urandom;
      sel  = 3'($urandom_range(7));
      if ($urandom_range(1) == 1) inst[6:0] = 7'h73;
      drive(1'($urandom_range(3) != 0), inst, sel, 4'($urandom_range(15)));
      out_ready = ($urandom_range(9) < 7);
      flush = ($urandom_range(39) == 0);
      applyStimulus();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Takes a 32-bit RISC-V instruction word plus a format select and produces an XLEN-wide immediate. The instruction, select and tag travel together as one item, and the immediate leaves with the item's tag.
- Input and output each use a valid/ready handshake. A 2-entry skid buffer decouples them, so the block runs at full throughput under backpressure.
- Sits between fetch/decode and the register-read stage.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 4, width of the sideband tag that travels with each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream item valid.
- in_ready  output  1  block can accept an item this cycle.
- in_instruction  input  32  raw instruction word.
- in_immediate_select  input  3  format select.
- in_tag  input  TAG_W  sideband tag, returned unchanged.
- out_valid  output  1  out_immediate/out_tag valid.
- out_ready  input  1  downstream accepts the item.
- out_immediate  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the presented item.

Behaviour:
- Format encoding and result:
  - 000 none -> 0.
  - 001 I -> sext(inst[31:20]).
  - 010 S -> sext({inst[31:25], inst[11:7]}).
  - 011 B -> sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 100 U -> sext({inst[31:12], 12'b0}).
  - 101 J -> sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 110 CSR zimm -> zero-extended inst[19:15].
  - 111 reserved -> 0.
- Sign extension is always from inst[31] up to XLEN. With XLEN=64 the U-type result is therefore sign-extended above bit 31.
- The immediate is computed combinationally at the input and stored in the buffer. out_immediate is a register output with no combinational path from the in_* ports.
- Transfers:
  - Input transfer happens when in_valid and in_ready are both high.
  - Output transfer happens when out_valid and out_ready are both high.
- Latency: an accepted item appears on out_valid on the next cycle.
- Buffer: 2 entries, FIFO order, with a count of 0..2.
  - out_valid = (count != 0).
  - in_ready = (count < 2). in_ready is registered and does not depend on out_ready in the same cycle.
- Simultaneous input and output transfer: count is unchanged and order is preserved.
  - With count=1, the new entry replaces the head on the next cycle.
  - With count=2, in_ready=0, so there is no input transfer.
- Full: count=2 and out_ready=0 -> in_ready=0; both entries hold stable.
- Empty: count=0 -> out_valid=0; out_immediate holds its last value (do not check).
- Output stability: while out_valid=1 and out_ready=0, out_immediate and out_tag must not change.
- Flush: next cycle count=0, out_valid=0, in_ready=1. Any input transfer in the flush cycle is dropped. Flush has priority over every other event.
- Reset (asserted at any time, including mid-transfer):
  - Immediately: count=0, out_valid=0, in_ready=0, out_immediate=0, out_tag=0.
  - On the first clk edge after rst_n rises: in_ready=1.

Optional Feature:
- Macro: IMM_GEN_SELECT_CHECK_EN.
- When defined:
  - Adds output port select_error (1 bit, reset 0), buffered with each entry and valid with out_valid.
  - select_error=1 for select 111, and for select 110 when inst[6:0] != 7'b1110011 (opcode other than SYSTEM).
  - The immediate is still 0 for 111.
- When undefined:
  - The port and its logic are absent.
  - Select 111 silently yields 0, and select 110 does not check the opcode.

Test Plan:
- Reset, then I-type: hold rst_n low while driving in_valid=1; in_ready=0 throughout. After release, push 0xFFF00093 with select 001 and tag 3 -> next cycle out_valid=1, out_immediate=0xFFFFFFFF, out_tag=3.
- All formats, XLEN=32, out_ready=1, back-to-back:
  - S 0xFE112E23 -> 0xFFFFFFFC.
  - U 0x12345037 -> 0x12345000.
  - J 0xFFDFF06F -> 0xFFFFFFFC.
  - CSR 0x000FD073 -> 0x0000001F.
  - Select 000 and 111 -> 0.
  - One result per cycle, in order.
- XLEN=64: U 0x80000037 -> 0xFFFFFFFF80000000. I 0x7FF00093 -> 0x00000000000007FF.
- Backpressure: out_ready=0, push tags 1 and 2.
  - After the second push, in_ready=0 and out_immediate is stable for 3 cycles.
  - Raise out_ready -> tags 1 then 2 emerge on consecutive cycles.
  - in_ready returns to 1 one cycle after the first pop.
- Flush and async reset: with 2 entries held, pulse flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the pushed item is never seen. Refill, then pulse rst_n low mid-cycle -> out_valid drops to 0 without a clock edge.
- With IMM_GEN_SELECT_CHECK_EN defined:
  - Select 111 -> select_error=1, immediate 0.
  - Select 110 on 0x000FD013 -> select_error=1.
  - Select 110 on 0x000FD073 -> select_error=0.
